// File: rtl/spi_master_shifter.sv
// SPI mode-0 master shifter: pops bytes from a TX FIFO and shifts them out MSB first on mosi.
// Latency: first SCLK rise 2+CLK_DIV clk after the pop request; one byte takes 16*CLK_DIV clk.
// Backpressure: a byte starts only when en=1 and fifo_empty=0; an empty FIFO or en=0 ends the burst via HOLD.
//
// Ports:
//   clk, rst_n             system clock (rising edge), asynchronous active-low reset
//   en                     permission to start new bytes (never aborts a byte in flight)
//   fifo_empty             TX FIFO empty flag
//   fifo_rd_data[7:0]      TX FIFO data, valid the cycle after a fifo_rd_en cycle
//   fifo_rd_en             registered one-cycle pop request per byte
//   sclk, mosi, miso, cs_n SPI bus, mode 0 (SCLK idles low, sample on rise, shift on fall)
//   rx_data[7:0]           last received byte
//   rx_valid               one-cycle strobe qualifying rx_data
//   busy                   high whenever the FSM is not in IDLE
//
// Optional feature: define SPI_RX_CAPTURE_EN to build the receive path. Without it miso
// is ignored and rx_data/rx_valid are tied to zero; transmit behaviour is unchanged.

module spi_master_shifter #(
    parameter int CLK_DIV = 4,  // clk cycles per SCLK half-period, 1..255
    parameter int CS_HOLD = 2   // clk cycles cs_n stays low after the last falling edge, 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    // Counters are sized to hold exactly 0..terminal; a parameter of 1 still needs one bit.
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

    localparam logic [DIV_W-1:0]  DIV_TC  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [DIV_W-1:0]   div_cnt;
    logic [2:0]         bit_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    // Bit 7 goes straight from fifo_rd_data to mosi at LOAD, so only the
    // remaining seven bits need to be kept for shifting.
    logic [6:0]         tx_sr;

    logic               can_pop;
    logic               div_tc;
    logic               sclk_rise;
    logic               sclk_fall;
    logic               last_fall;
    logic               hold_done;

    assign can_pop   = en && !fifo_empty;
    assign div_tc    = (div_cnt == DIV_TC);
    // Edge strobes are qualified by the current sclk level: a terminal count
    // with sclk low produces a rising edge, with sclk high a falling edge.
    assign sclk_rise = (state == ST_SHIFT) && div_tc && !sclk;
    assign sclk_fall = (state == ST_SHIFT) && div_tc && sclk;
    assign last_fall = sclk_fall && (bit_cnt == 3'd7);
    assign hold_done = (state == ST_HOLD) && (hold_cnt == HOLD_TC);

    assign busy = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (can_pop) begin
                    state_nxt = ST_POP;
                end
            end
            ST_POP: begin
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Back-to-back bytes skip HOLD so cs_n never blips high inside a burst.
                if (last_fall) begin
                    state_nxt = can_pop ? ST_POP : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit datapath, SCLK generation and chip select
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_rd_en <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= 3'd0;
            hold_cnt   <= '0;
            tx_sr      <= 7'd0;
        end else begin
            // POP is only ever entered from IDLE or SHIFT, so this is a
            // single-cycle pulse aligned with the POP state.
            fifo_rd_en <= (state_nxt == ST_POP);

            case (state)
                ST_LOAD: begin
                    tx_sr   <= fifo_rd_data[6:0];
                    mosi    <= fifo_rd_data[7];
                    cs_n    <= 1'b0;
                    sclk    <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= 3'd0;
                end
                ST_SHIFT: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        // Falling edge: advance to the next bit, except after
                        // bit 0 where mosi keeps its value between bytes.
                        if (sclk && (bit_cnt != 3'd7)) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            mosi    <= tx_sr[6];
                            tx_sr   <= {tx_sr[5:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                    if (last_fall) begin
                        hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_done) begin
                        cs_n     <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
`ifdef SPI_RX_CAPTURE_EN
    logic [7:0] rx_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr    <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= last_fall;
            if (sclk_rise) begin
                rx_sr <= {rx_sr[6:0], miso};
            end
            // All eight rising edges precede the 8th falling edge, so rx_sr
            // already holds the complete byte here.
            if (last_fall) begin
                rx_data <= rx_sr;
            end
        end
    end
`else
    logic unused_miso;
    logic unused_sclk_rise;

    assign unused_miso      = miso;
    assign unused_sclk_rise = sclk_rise;
    assign rx_data          = 8'h00;
    assign rx_valid         = 1'b0;
`endif

endmodule
